// File: rtl/alu_issue_control.sv
// Issue/writeback sequencer wrapped around the 16-bit ALU datapath: reads
// operands from a 16x16 register file, strobes the ALU and commits result/flags.
//
// state   | meaning
// IDLE    | waiting for an instruction, instr_ready high
// DECODE  | read operands / classify opcode
// EXEC    | ALU strobe high for exactly one cycle
// CAPTURE | sample ALU result and flags into hold registers
// WRITE   | commit result to rd and flags to status, pulse done
module alu_issue_control #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic [3:0]       alu_shift,
    output logic             alu_execute,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic [3:0]       status,
    output logic             done,
    output logic             illegal,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_CAPTURE,
        S_WRITE
    } state_t;

    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_LDI = 4'd9;

    state_t           state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [3:0]       alu_shift_q, alu_shift_d;
    logic             exec_q, exec_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             is_alu_q, is_alu_d;
    logic [3:0]       status_q, status_d;
    logic             reg_we;
    logic [WIDTH-1:0] regs_q [NREGS];

    logic [3:0]       op, rd, rs, rt;
    logic [WIDTH-1:0] rs_val, rt_val, imm;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:8];
    assign rs  = instr_q[7:4];
    assign rt  = instr_q[3:0];
    assign imm = {{(WIDTH-8){1'b0}}, instr_q[7:0]};

    // R0 is hardwired to zero on every read port
    assign rs_val   = (rs == 4'd0) ? '0 : regs_q[rs];
    assign rt_val   = (rt == 4'd0) ? '0 : regs_q[rt];
    assign dbg_data = (dbg_addr == 4'd0) ? '0 : regs_q[dbg_addr];

    assign instr_ready = (state_q == S_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign alu_shift   = alu_shift_q;
    assign alu_execute = exec_q;
    assign status      = status_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        alu_shift_d = alu_shift_q;
        exec_d      = 1'b0;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        res_d       = res_q;
        flags_d     = flags_q;
        is_alu_d    = is_alu_q;
        status_d    = status_q;
        reg_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op <= OP_ROR) begin
                    alu_a_d     = rs_val;
                    alu_b_d     = rt_val;
                    alu_sel_d   = op;
                    alu_shift_d = rt;
                    is_alu_d    = 1'b1;
                    state_d     = S_EXEC;
                end else if (op == OP_LDI) begin
                    res_d    = imm;
                    is_alu_d = 1'b0;
                    state_d  = S_WRITE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_EXEC: begin
                exec_d  = 1'b1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_d   = alu_result;
                flags_d = alu_flags;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                reg_we = 1'b1;
                done_d = 1'b1;
                if (is_alu_q) status_d = flags_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_shift_q <= '0;
            exec_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            is_alu_q    <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_shift_q <= alu_shift_d;
            exec_q      <= exec_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            is_alu_q    <= is_alu_d;
            status_q    <= status_d;
        end
    end

    // Writes to R0 are dropped so its storage stays zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (reg_we && (rd != 4'd0)) begin
            regs_q[rd] <= res_q;
        end
    end

endmodule
